// File: rtl/parametrised_reset_pio.sv
// ============================================================================
//  Module      : parametrised_reset_pio
//  Description : Avalon-MM output register bank driving reset/control lines,
//                with per-bit level or self-clearing pulse mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parametrised_reset_pio #(
    parameter int                 WIDTH         = 8,
    parameter int                 CNT_W         = 16,
    parameter logic [WIDTH-1:0]   RESET_VALUE   = '0,
    parameter logic [CNT_W-1:0]   DEFAULT_PULSE = CNT_W'(16),
    parameter logic [WIDTH-1:0]   INVERT_MASK   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port,
    output logic              busy
);

    localparam logic [2:0] c_ADDR_DATA   = 3'd0;
    localparam logic [2:0] c_ADDR_MODE   = 3'd1;
    localparam logic [2:0] c_ADDR_PLEN   = 3'd2;
    localparam logic [2:0] c_ADDR_STATUS = 3'd3;
    localparam logic [2:0] c_ADDR_SET    = 3'd4;
    localparam logic [2:0] c_ADDR_CLEAR  = 3'd5;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mode;
    logic [CNT_W-1:0] r_plen;
    logic [CNT_W-1:0] r_cnt;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_nd;
    logic             w_trig;
    logic [WIDTH-1:0] w_data_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_load;
    logic [31:0]      w_rd_data;
    logic [31:0]      w_rd_mode;
    logic [31:0]      w_rd_plen;
    logic [63:0]      w_status_wide;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];

    always_comb begin
        w_nd = r_data;
        if (w_wr) begin
            case (address)
                c_ADDR_DATA:  w_nd = w_wdata;
                c_ADDR_SET:   w_nd = r_data | w_wdata;
                c_ADDR_CLEAR: w_nd = r_data & ~w_wdata;
                default:      w_nd = r_data;
            endcase
        end
    end

    // Only a 0->1 edge on a pulse-mode bit (re)starts the shared countdown.
    assign w_trig = |(w_nd & ~r_data & r_mode);
    assign w_load = (r_plen == '0) ? CNT_W'(1) : r_plen;

    always_comb begin
        w_data_next = w_nd;
        w_cnt_next  = r_cnt;
        if (w_trig) begin
            w_cnt_next = w_load;
        end else if (r_cnt == CNT_W'(1)) begin
            w_data_next = w_nd & ~r_mode;
            w_cnt_next  = '0;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CNT_W'(1);
            // No pulse bits left high: the countdown has nothing to time.
            if ((w_nd & r_mode) == '0) begin
                w_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= RESET_VALUE;
            r_mode <= '0;
            r_plen <= DEFAULT_PULSE;
            r_cnt  <= '0;
        end else begin
            r_data <= w_data_next;
            r_cnt  <= w_cnt_next;
            if (w_wr && address == c_ADDR_MODE) begin
                r_mode <= w_wdata;
            end
            if (w_wr && address == c_ADDR_PLEN) begin
                r_plen <= writedata[CNT_W-1:0];
            end
        end
    end

    assign busy     = (r_cnt != '0);
    assign out_port = r_data ^ INVERT_MASK;

    always_comb begin
        w_rd_data = '0;
        w_rd_mode = '0;
        w_rd_plen = '0;
        w_rd_data[WIDTH-1:0] = r_data;
        w_rd_mode[WIDTH-1:0] = r_mode;
        w_rd_plen[CNT_W-1:0] = r_plen;
    end

    assign w_status_wide = {{(56-CNT_W){1'b0}}, r_cnt, 7'd0, busy};

    always_comb begin
        case (address)
            c_ADDR_DATA:   readdata = w_rd_data;
            c_ADDR_MODE:   readdata = w_rd_mode;
            c_ADDR_PLEN:   readdata = w_rd_plen;
            c_ADDR_STATUS: readdata = w_status_wide[31:0];
            default:       readdata = '0;
        endcase
    end

endmodule

`default_nettype wire
